// File: rtl/jt7759_pkg.sv
// Shared definitions for the JT7759 slave-mode sample feeder.
package jt7759_pkg;

  localparam int unsigned ADDR_W        = 17;
  localparam int unsigned WR_CYCLES_DEF = 2;
  localparam int unsigned TICK_W        = 4;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_FETCH,
    FEED_WAIT_DRQ,
    FEED_SETUP,
    FEED_STROBE,
    FEED_HOLD
  } feed_state_t;

endpackage

// File: rtl/jt7759_feed_strobe.sv
// cen-paced SETUP/STROBE/HOLD write sequencer; ack_c marks the final HOLD tick.
module jt7759_feed_strobe
  import jt7759_pkg::*;
#(
  parameter int unsigned WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cen,
  input  logic       go,
  input  logic [7:0] data,
  output logic       cs,
  output logic       wrn,
  output logic [7:0] dout,
  output logic       ack_c
);

  feed_state_t             st, st_nxt;
  logic [TICK_W-1:0]       tick, tick_nxt;
  logic                    cs_nxt, wrn_nxt;
  logic [7:0]              dout_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st   <= FEED_IDLE;
      tick <= '0;
      cs   <= 1'b0;
      wrn  <= 1'b1;
      dout <= '0;
    end else begin
      st   <= st_nxt;
      tick <= tick_nxt;
      cs   <= cs_nxt;
      wrn  <= wrn_nxt;
      dout <= dout_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    tick_nxt = tick;
    cs_nxt   = cs;
    wrn_nxt  = wrn;
    dout_nxt = dout;
    ack_c    = 1'b0;
    case (st)
      FEED_IDLE: if (go) begin
        st_nxt   = FEED_SETUP;
        cs_nxt   = 1'b1;
        wrn_nxt  = 1'b1;
        dout_nxt = data;
      end
      FEED_SETUP: if (cen) begin
        st_nxt   = FEED_STROBE;
        wrn_nxt  = 1'b0;
        tick_nxt = TICK_W'(WR_CYCLES - 1);
      end
      // wrn stays low for WR_CYCLES cen ticks
      FEED_STROBE: if (cen) begin
        if (tick == '0) begin
          st_nxt  = FEED_HOLD;
          wrn_nxt = 1'b1;
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
      FEED_HOLD: if (cen) begin
        st_nxt = FEED_IDLE;
        cs_nxt = 1'b0;
        ack_c  = 1'b1;
      end
      default: begin
        st_nxt  = FEED_IDLE;
        cs_nxt  = 1'b0;
        wrn_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/jt7759_feeder.sv
// Streams sample bytes from ROM into a slave-mode JT7759 following its drqn handshake.
module jt7759_feeder
  import jt7759_pkg::*;
#(
  parameter int unsigned WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cen,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  input  logic              drqn,
  output logic              cs,
  output logic              wrn,
  output logic [7:0]        dout
);

  feed_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt, addr_nxt;
  logic [7:0]        byte_buf, buf_nxt;
  logic              drq_l, abort_pend, abort_nxt;
  logic              busy_nxt, done_nxt, rom_cs_nxt;
  logic              go_c, ack_c;

  always_ff @(posedge clk) begin
    if (!rstn) drq_l <= 1'b1;
    else       drq_l <= drqn;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FEED_IDLE;
      cnt        <= '0;
      rom_addr   <= '0;
      byte_buf   <= '0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_cs     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rom_addr   <= addr_nxt;
      byte_buf   <= buf_nxt;
      abort_pend <= abort_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      rom_cs     <= rom_cs_nxt;
    end
  end

  // FEED_SETUP spans the whole write; the strobe sequencer walks its phases
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = rom_addr;
    buf_nxt    = byte_buf;
    abort_nxt  = abort_pend;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    rom_cs_nxt = rom_cs;
    go_c       = 1'b0;
    case (state)
      FEED_IDLE: if (start && !abort) begin
        addr_nxt  = start_addr;
        cnt_nxt   = length;
        abort_nxt = 1'b0;
        if (length != '0) begin
          state_nxt  = FEED_FETCH;
          rom_cs_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end else begin
          done_nxt = 1'b1;
        end
      end
      FEED_FETCH: begin
        if (abort) begin
          state_nxt  = FEED_IDLE;
          rom_cs_nxt = 1'b0;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
        end else if (rom_cs && rom_ok) begin
          state_nxt  = FEED_WAIT_DRQ;
          buf_nxt    = rom_data;
          addr_nxt   = rom_addr + ADDR_W'(1);
          rom_cs_nxt = 1'b0;
        end
      end
      FEED_WAIT_DRQ: begin
        if (abort) begin
          state_nxt = FEED_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (cen && !drq_l) begin
          state_nxt = FEED_SETUP;
          go_c      = 1'b1;
        end
      end
      FEED_SETUP: begin
        // an abort here lets the current write finish before stopping
        abort_nxt = abort_pend | abort;
        if (ack_c) begin
          cnt_nxt = cnt - ADDR_W'(1);
          if (cnt == ADDR_W'(1) || abort_pend || abort) begin
            state_nxt = FEED_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            abort_nxt = 1'b0;
          end else begin
            state_nxt  = FEED_FETCH;
            rom_cs_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = FEED_IDLE;
        busy_nxt   = 1'b0;
        rom_cs_nxt = 1'b0;
      end
    endcase
  end

  jt7759_feed_strobe #(
    .WR_CYCLES (WR_CYCLES)
  ) u_strobe (
    .clk   (clk),
    .rstn  (rstn),
    .cen   (cen),
    .go    (go_c),
    .data  (byte_buf),
    .cs    (cs),
    .wrn   (wrn),
    .dout  (dout),
    .ack_c (ack_c)
  );

endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: ROM and JT7759 slave models, per-scenario checking tasks.
module tb_jt7759_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0, cen = 1'b0, start = 1'b0, abort = 1'b0;
  logic        rom_ok = 1'b0, drqn = 1'b1;
  logic [16:0] start_addr = '0, length = '0, rom_addr;
  logic [7:0]  rom_data = '0, dout;
  logic        busy, done, rom_cs, cs, wrn;

  always #5 clk = ~clk;

  jt7759_feeder #(.WR_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .drqn(drqn),
    .cs(cs), .wrn(wrn), .dout(dout)
  );

  int passed = 0, total = 0;

  // ROM contents: explicit entries override a fixed address hash
  logic [7:0] mem [logic [16:0]];
  function automatic logic [7:0] rom_val(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'(a[7:0] * 8'd13) ^ a[16:9];
  endfunction

  int   rom_lat = 1, rom_wait = 0;
  bit   rom_auto = 1'b1, force_ok = 1'b0;
  logic [7:0] force_data = '0;
  always @(posedge clk) begin
    #2;
    if (!rom_auto) begin
      rom_ok = force_ok; rom_data = force_data;
    end else if (rom_cs) begin
      if (rom_wait >= rom_lat) begin rom_ok = 1'b1; rom_data = rom_val(rom_addr); end
      else begin rom_ok = 1'b0; rom_wait++; end
    end else begin
      rom_ok = 1'b0; rom_wait = 0;
    end
  end

  always @(posedge clk) cen <= #2 1'($urandom_range(0, 1));

  // chip: 0 = never requests, 1 = slave handshake, 2 = drqn held low
  int   chip_mode = 0, chip_dly = 0;
  logic wrn_prev_c = 1'b1;
  always @(posedge clk) begin
    #2;
    if (chip_mode == 0) drqn = 1'b1;
    else if (chip_mode == 2) drqn = 1'b0;
    else if (wrn_prev_c && !wrn) begin drqn = 1'b1; chip_dly = $urandom_range(2, 8); end
    else if (chip_dly > 0) chip_dly--;
    else drqn = 1'b0;
    wrn_prev_c = wrn;
  end

  // bus observer: records bytes written, strobe lengths and handshake events
  logic [7:0]  wr_q[$];
  int          wrn_len_q[$], cs_len_q[$];
  logic [16:0] rd_q[$];
  int          done_cnt, glitch, busy_err, cs_rise, rom_cs_cycles, cs_ticks, wrn_ticks;
  logic        cs_p = 1'b0, wrn_p = 1'b1;
  logic [7:0]  dout_p = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (cs && !cs_p) begin cs_rise++; cs_ticks = 0; end
      if (cs && cen) cs_ticks++;
      if (!cs && cs_p) cs_len_q.push_back(cs_ticks);
      if (!wrn && wrn_p) begin wr_q.push_back(dout); wrn_ticks = 0; end
      if (!wrn && cen) wrn_ticks++;
      if (wrn && !wrn_p) wrn_len_q.push_back(wrn_ticks);
      if (cs && cs_p && dout !== dout_p) glitch++;
      if (done) done_cnt++;
      if (done && busy) busy_err++;
      if (rom_cs) rom_cs_cycles++;
      if (rom_cs && rom_ok) rd_q.push_back(rom_addr);
    end
    cs_p = cs; wrn_p = wrn; dout_p = dout;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_stats();
    wr_q.delete(); wrn_len_q.delete(); cs_len_q.delete(); rd_q.delete();
    done_cnt = 0; glitch = 0; busy_err = 0; cs_rise = 0; rom_cs_cycles = 0;
  endtask

  task automatic start_xfer(input logic [16:0] a, input logic [16:0] n);
    start = 1'b1; start_addr = a; length = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(done_cnt >= 1 && !busy) && k < budget) begin step(); k++; end
    total++;
    if (k >= budget) $display("FAIL %s_timeout: no done within %0d clocks", name, budget);
    else passed++;
    step(4);
  endtask

  task automatic test_reset();
    int k;
    chip_mode = 2; rom_lat = 1; clear_stats();
    start_xfer(17'h00040, 17'd1);
    k = 0;
    while (wrn !== 1'b0 && k < 200) begin step(); k++; end
    total++; if (k >= 200) $display("FAIL rst_reach_strobe: wrn never fell"); else passed++;
    rstn = 1'b0;
    step();
    total++; if (wrn !== 1'b1) $display("FAIL rst_wrn: got %b want 1", wrn); else passed++;
    total++; if (cs !== 1'b0) $display("FAIL rst_cs: got %b want 0", cs); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (rom_cs !== 1'b0 || done !== 1'b0) $display("FAIL rst_romcs_done: got %b/%b want 0/0", rom_cs, done); else passed++;
    total++; if (rom_addr !== 17'h0 || dout !== 8'h0) $display("FAIL rst_addr_dout: got %h/%h want 0/0", rom_addr, dout); else passed++;
    step(2);
    rstn = 1'b1; chip_mode = 0;
    step(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    logic [7:0] got;
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    mem[17'h00100] = 8'hA1; mem[17'h00101] = 8'hB2; mem[17'h00102] = 8'hC3;
    chip_mode = 1; rom_lat = 2; clear_stats();
    start_xfer(17'h00100, 17'd3);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
    wait_idle("basic", 600);
    total++; if (wr_q.size() != 3) $display("FAIL basic_nwrites: got %0d want 3", wr_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
      total++; if (got !== exp[i]) $display("FAIL basic_byte%0d: got %h want %h", i, got, exp[i]); else passed++;
      total++; if (i >= wrn_len_q.size() || wrn_len_q[i] != 2) $display("FAIL basic_wrn_len%0d: wrn low not 2 cen ticks", i); else passed++;
      total++; if (i >= cs_len_q.size() || cs_len_q[i] != 4) $display("FAIL basic_cs_len%0d: cs high not 4 cen ticks", i); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else passed++;
    total++; if (rom_addr !== 17'h00103) $display("FAIL basic_addr: got %h want 00103", rom_addr); else passed++;
    total++; if (glitch != 0 || busy_err != 0) $display("FAIL basic_dout_busy: glitch %0d busy_err %0d want 0/0", glitch, busy_err); else passed++;
  endtask

  task automatic test_wrap();
    chip_mode = 1; rom_lat = 0; clear_stats();
    start_xfer(17'h1FFFF, 17'd2);
    wait_idle("wrap", 400);
    total++; if (rd_q.size() != 2) $display("FAIL wrap_nreads: got %0d want 2", rd_q.size()); else passed++;
    total++; if (rd_q.size() < 1 || rd_q[0] !== 17'h1FFFF) $display("FAIL wrap_rd0: want 1ffff"); else passed++;
    total++; if (rd_q.size() < 2 || rd_q[1] !== 17'h00000) $display("FAIL wrap_rd1: want 00000"); else passed++;
    total++; if (wr_q.size() < 2 || wr_q[1] !== rom_val(17'h0)) $display("FAIL wrap_byte1: want %h", rom_val(17'h0)); else passed++;
    total++; if (rom_addr !== 17'h00001) $display("FAIL wrap_addr: got %h want 00001", rom_addr); else passed++;
  endtask

  task automatic test_zero();
    chip_mode = 2; clear_stats();
    start_xfer(17'h00055, 17'd0);
    total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else passed++;
    step(10);
    total++; if (rom_cs_cycles != 0) $display("FAIL zero_romcs: got %0d cycles want 0", rom_cs_cycles); else passed++;
    total++; if (done_cnt != 1 || cs_rise != 0) $display("FAIL zero_count: done %0d cs %0d want 1/0", done_cnt, cs_rise); else passed++;
  endtask

  task automatic test_abort_strobe();
    int k;
    chip_mode = 1; rom_lat = 1; clear_stats();
    start_xfer(17'h00300, 17'd4);
    k = 0;
    while (wr_q.size() < 2 && k < 400) begin step(); k++; end
    total++; if (k >= 400) $display("FAIL abs_reach: second write never started"); else passed++;
    abort = 1'b1; step(); abort = 1'b0;
    wait_idle("abs", 200);
    step(20);
    total++; if (wr_q.size() != 2 || cs_rise != 2) $display("FAIL abs_writes: got %0d/%0d want 2/2", wr_q.size(), cs_rise); else passed++;
    total++; if (wrn_len_q.size() < 2 || wrn_len_q[1] != 2) $display("FAIL abs_full_strobe: second strobe truncated"); else passed++;
    total++; if (cs_len_q.size() < 2 || cs_len_q[1] != 4) $display("FAIL abs_full_cycle: second write cycle truncated"); else passed++;
    total++; if (wr_q.size() < 2 || wr_q[1] !== rom_val(17'h00301)) $display("FAIL abs_byte1: want %h", rom_val(17'h00301)); else passed++;
    total++; if (done_cnt != 1) $display("FAIL abs_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_abort_fetch();
    rom_auto = 1'b0; force_ok = 1'b0; chip_mode = 2; clear_stats();
    start_xfer(17'h00200, 17'd2);
    total++; if (rom_cs !== 1'b1) $display("FAIL abf_romcs_on: got %b want 1", rom_cs); else passed++;
    step(3);
    abort = 1'b1; step(); abort = 1'b0;
    total++; if (rom_cs !== 1'b0) $display("FAIL abf_romcs_off: got %b want 0", rom_cs); else passed++;
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL abf_done: got done %b busy %b want 1/0", done, busy); else passed++;
    force_ok = 1'b1; force_data = 8'hEE;
    step(2);
    force_ok = 1'b0;
    step(30);
    total++; if (cs_rise != 0 || wr_q.size() != 0) $display("FAIL abf_late_data: got %0d writes want 0", cs_rise); else passed++;
    total++; if (done_cnt != 1) $display("FAIL abf_done_cnt: got %0d want 1", done_cnt); else passed++;
    rom_auto = 1'b1;
  endtask

  task automatic test_rom_delay();
    chip_mode = 2; rom_lat = 20; clear_stats();
    start_xfer(17'h00400, 17'd1);
    step(16);
    total++; if (cs !== 1'b0 || cs_rise != 0) $display("FAIL dly_cs_early: cs %b rises %0d want 0/0", cs, cs_rise); else passed++;
    total++; if (rom_cs !== 1'b1) $display("FAIL dly_romcs: got %b want 1", rom_cs); else passed++;
    wait_idle("dly", 200);
    total++; if (wr_q.size() != 1 || wr_q[0] !== rom_val(17'h00400)) $display("FAIL dly_byte: want %h", rom_val(17'h00400)); else passed++;
    total++; if (glitch != 0) $display("FAIL dly_dout_stable: got %0d changes want 0", glitch); else passed++;
    total++; if (cs_len_q.size() != 1 || cs_len_q[0] != 4) $display("FAIL dly_cs_len: write cycle not 4 cen ticks"); else passed++;
    rom_lat = 1;
  endtask

  task automatic test_random();
    logic [16:0] a, n;
    logic [7:0]  exp_b[$];
    logic [16:0] exp_a[$];
    int bad;
    for (int it = 0; it < 6; it++) begin
      a = 17'($urandom); n = 17'($urandom_range(1, 6));
      rom_lat = $urandom_range(0, 4); chip_mode = 1; clear_stats();
      exp_b.delete(); exp_a.delete();
      for (int i = 0; i < int'(n); i++) begin
        exp_a.push_back(17'(a + 17'(i)));
        exp_b.push_back(rom_val(17'(a + 17'(i))));
      end
      start_xfer(a, n);
      wait_idle("rnd", int'(n) * 100);
      total++; if (wr_q.size() != exp_b.size()) $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, wr_q.size(), exp_b.size()); else passed++;
      bad = 0;
      for (int i = 0; i < exp_b.size(); i++) begin
        if (i >= wr_q.size() || wr_q[i] !== exp_b[i]) bad++;
        if (i >= rd_q.size() || rd_q[i] !== exp_a[i]) bad++;
        if (i >= wrn_len_q.size() || wrn_len_q[i] != 2) bad++;
      end
      total++; if (bad != 0) $display("FAIL rnd%0d_stream: %0d wrong bytes/addresses/strobes want 0", it, bad); else passed++;
      total++; if (done_cnt != 1 || busy_err != 0 || glitch != 0) $display("FAIL rnd%0d_ctrl: done %0d busy_err %0d glitch %0d want 1/0/0", it, done_cnt, busy_err, glitch); else passed++;
      total++; if (rom_addr !== 17'(a + n)) $display("FAIL rnd%0d_addr: got %h want %h", it, rom_addr, 17'(a + n)); else passed++;
    end
  endtask

  initial begin
    step(3);
    rstn = 1'b1;
    step(2);
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_abort_strobe();
    test_abort_fetch();
    test_rom_delay();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jt7759_feeder.md
# jt7759_feeder

Host-side byte streamer for a JT7759 running in slave mode (`mdn`=0). It owns the transmitting end of the slave data handshake: it watches `drqn`, prefetches the next sample byte from ROM and writes it into the chip with a `cs`/`wrn` strobe. It sits in the game/system top level between the sample ROM arbiter and the JT7759 passive interface, and replaces a CPU-driven feed loop.

## Interface
Parameters:
- `WR_CYCLES`, 2: number of `cen` ticks that `wrn` is held low per write (1..15).

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous active-low reset.
- `cen`  in  1  bus-timing clock enable; all strobe phases advance only on `cen`.
- `start`  in  1  one-cycle request to begin a transfer; ignored while `busy`.
- `start_addr`  in  17  first ROM byte address, sampled with `start`.
- `length`  in  17  number of bytes to send, sampled with `start`.
- `abort`  in  1  stop the current transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at the end of a transfer, whether completed or aborted.
- `rom_cs`  out  1  ROM read request.
- `rom_addr`  out  17  ROM byte address.
- `rom_data`  in  8  ROM read data.
- `rom_ok`  in  1  ROM data valid.
- `drqn`  in  1  data request from the JT7759, active low.
- `cs`  out  1  chip select to the JT7759.
- `wrn`  out  1  write strobe to the JT7759, active low.
- `dout`  out  8  data bus to the JT7759.

## Operation
- `drqn` is registered once (`drq_l`). All decisions use `drq_l`.
- States and transitions:
  - IDLE → FETCH on `start` when `length`≠0.
  - IDLE → `done` pulse on `start` when `length`=0, with no ROM access.
  - FETCH: `rom_cs`=1 until `rom_ok`. Then latch `rom_data` into `buf`, increment `rom_addr`, → WAIT_DRQ.
  - WAIT_DRQ: waits for a `cen` tick with `drq_l`=0, then → SETUP.
  - SETUP: one `cen` tick; `cs`=1, `wrn`=1, `dout`=`buf`. → STROBE.
  - STROBE: `WR_CYCLES` `cen` ticks with `cs`=1, `wrn`=0. → HOLD.
  - HOLD: one `cen` tick with `cs`=1, `wrn`=1. Decrement `cnt`. If `cnt` is now 0, → IDLE with a `done` pulse; else → FETCH.
- `dout` holds `buf` from SETUP through HOLD inclusive. It never changes while `cs`=1.
- `rom_addr` is 17-bit and wraps from 0x1FFFF to 0x00000.
- `cnt` is loaded from `length`.
- `abort` handling:
  - In FETCH or WAIT_DRQ: → IDLE on the next clock, with `rom_cs` dropped and a `done` pulse.
  - In SETUP, STROBE or HOLD: the current write completes through HOLD, then → IDLE with `done`. A strobe is never truncated.
- A `start` that coincides with `abort` in IDLE is ignored.
- `rom_data` arriving after an abort is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_cs`=0, `rom_addr`=0, `cs`=0, `wrn`=1, `dout`=0. The FSM is in IDLE and `cnt`=0.
- Reset mid-strobe forces `wrn`=1 and `cs`=0 on the next clock.
- `busy` rises the clock after `start` is accepted. It falls in the same cycle `done` pulses.
- Latency from `drqn` falling to `cs` rising: 1 clock of sync, plus wait for the next `cen`, plus one more clock.
- Write cycle length: `WR_CYCLES`+2 `cen` ticks.
- The JT7759 releases `drqn` on the `wrn` falling edge. The next fetch overlaps the chip's decode time.
- If `drq_l` is already 0 when WAIT_DRQ is entered, SETUP starts on the next `cen`.
- `rom_ok` with `rom_cs`=0 is ignored.

## Structure
- Shared package `jt7759_pkg`:
  - FSM state encoding (`FEED_IDLE` … `FEED_HOLD`).
  - Address width constant (17).
  - Default `WR_CYCLES`.
- One sub-module, `jt7759_feed_strobe`. It is the `cen`-paced SETUP/STROBE/HOLD sequencer, with `go`/`ack` handshake and `cs`/`wrn` outputs. The fetch/count FSM stays in the top module.

## Test plan
- Reset with `rstn`=0 for 3 clocks, strobe held mid-write → `wrn`=1, `cs`=0, `busy`=0 on the first reset clock.
- `start`, `start_addr`=0x00100, `length`=3, ROM bytes 0xA1/0xB2/0xC3, JT7759 model in slave mode → three writes in order, each with `wrn` low for exactly 2 `cen` ticks. Exactly one `done` pulse, after the third HOLD. Final `rom_addr`=0x00103.
- `start_addr`=0x1FFFF, `length`=2 → reads at 0x1FFFF then 0x00000.
- `length`=0 → `done` the cycle after `start`; `rom_cs` never asserts.
- `abort` during STROBE of byte 2 of 4 → byte 2 write completes fully, no third `cs`, one `done`. `abort` during FETCH with `rom_ok` late → `rom_cs` drops next clock and the late data is not written.
- `rom_ok` delayed 20 clocks, `drqn` held low → `cs` stays 0 until data is latched. `dout` is stable from SETUP through HOLD.
